// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON round-constant engine.
// The constant table is padded to 16 entries so a 4-bit index is always in range.
package ascon_pack;

    localparam int ROUNDS_A = 12;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        FSM_IDLE,
        FSM_RUN,
        FSM_DONE
    } type_fsm;

    localparam logic [7:0] ROUND_CONSTANT [16] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
        8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/add_constant.sv
// One ASCON constant-addition lane: XORs the round constant into word 2, byte 0.
// Purely combinational so several lanes can be chained inside one clock.
module add_constant
    import ascon_pack::*;
(
    input  type_state   state_i,
    input  logic [3:0]  round_i,
    output type_state   state_o
);

    always_comb begin
        state_o        = state_i;
        state_o[2][7:0] = state_i[2][7:0] ^ ROUND_CONSTANT[round_i];
    end

endmodule

// File: rtl/ascon_const_iter.sv
// Iterative round-constant engine: applies UNROLL constant additions per clock
// over rounds (12-Nr)..11, with a start/done handshake for the permutation controller.
module ascon_const_iter
    import ascon_pack::*;
#(
    parameter int UNROLL   = 1,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       clear_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic [3:0] round_o,
    output logic       busy_o,
    output logic       done_o
);

    if ((ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0 ||
        (ROUNDS_B != 6 && ROUNDS_B != 8)) begin : g_bad_params
        $error("ascon_const_iter: UNROLL must divide 12 and ROUNDS_B, ROUNDS_B must be 6 or 8");
    end

    localparam logic [3:0] PB_FIRST   = 4'(ROUNDS_A - ROUNDS_B);
    localparam logic [3:0] ROUND_STEP = 4'(UNROLL);
    localparam logic [3:0] ROUND_LAST = 4'(ROUNDS_A);

    type_fsm    fsm_q, fsm_d;
    type_state  state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       done_q, done_d;

    // Lane k applies constant round_q + k; the last lane output is the next state.
    type_state lane [UNROLL+1];
    assign lane[0] = state_q;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_lane
        add_constant u_add_constant (
            .state_i (lane[gi]),
            .round_i (round_q + 4'(gi)),
            .state_o (lane[gi+1])
        );
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= FSM_IDLE;
            state_q <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        if (clear_i) begin
            fsm_d   = FSM_IDLE;
            state_d = '0;
            round_d = '0;
        end else begin
            case (fsm_q)
                FSM_IDLE, FSM_DONE: begin
                    if (start_i) begin
                        fsm_d   = FSM_RUN;
                        state_d = state_i;
                        round_d = mode_i ? 4'd0 : PB_FIRST;
                    end
                end
                FSM_RUN: begin
                    state_d = lane[UNROLL];
                    round_d = round_q + ROUND_STEP;
                    if (round_q + ROUND_STEP == ROUND_LAST) begin
                        fsm_d  = FSM_DONE;
                        done_d = 1'b1;
                    end
                end
                default: begin
                    fsm_d = FSM_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = (fsm_q == FSM_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_const_iter.sv
// Self-checking bench: three engine configurations checked against a round-by-round
// reference built from the constant list, plus reset/clear/start corner sequences.
module tb_ascon_const_iter;
    import ascon_pack::*;

    localparam int NDUT = 3;
    localparam int UN [NDUT] = '{1, 1, 3};
    localparam int RB [NDUT] = '{6, 8, 6};
    localparam logic [7:0] RC [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    logic       clk;
    logic       rstn  [NDUT];
    logic       start [NDUT];
    logic       mode  [NDUT];
    logic       clr   [NDUT];
    type_state  st_i  [NDUT];
    type_state  st_o  [NDUT];
    logic [3:0] rnd   [NDUT];
    logic       busy  [NDUT];
    logic       done  [NDUT];

    int tests = 0;
    int fails = 0;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        ascon_const_iter #(.UNROLL(UN[gi]), .ROUNDS_B(RB[gi])) u_dut (
            .clock_i  (clk),
            .resetb_i (rstn[gi]),
            .start_i  (start[gi]),
            .mode_i   (mode[gi]),
            .clear_i  (clr[gi]),
            .state_i  (st_i[gi]),
            .state_o  (st_o[gi]),
            .round_o  (rnd[gi]),
            .busy_o   (busy[gi]),
            .done_o   (done[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] fold(input int lo, input int hi);
        logic [7:0] x = 8'h00;
        for (int i = lo; i < hi; i++) x = x ^ RC[i];
        return x;
    endfunction

    function automatic type_state apply_rounds(input type_state s, input int lo, input int hi);
        type_state r = s;
        r[2][7:0] = r[2][7:0] ^ fold(lo, hi);
        return r;
    endfunction

    function automatic type_state rand_state();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
        return type_state'(t);
    endfunction

    // Full cycle-by-cycle check of one operation from an IDLE/DONE engine.
    task automatic run_op(input int d, input type_state s, input logic m);
        int nr, r0, n, u;
        u  = UN[d];
        nr = m ? 12 : RB[d];
        r0 = 12 - nr;
        n  = nr / u;
        st_i[d]  = s;
        mode[d]  = m;
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        mode[d]  = 1'($urandom & 1);
        st_i[d]  = rand_state();
        chk("accept_busy", busy[d], 1);
        chk("accept_round", rnd[d], r0);
        chk("accept_state", st_o[d], s);
        chk("accept_done", done[d], 0);
        for (int k = 1; k <= n; k++) begin
            step();
            chk("run_round", rnd[d], r0 + k*u);
            chk("run_state", st_o[d], apply_rounds(s, r0, r0 + k*u));
            chk("run_done", done[d], (k == n) ? 1 : 0);
            chk("run_busy", busy[d], (k < n) ? 1 : 0);
        end
        step();
        chk("hold_done", done[d], 0);
        chk("hold_round", rnd[d], 12);
        chk("hold_state", st_o[d], apply_rounds(s, r0, 12));
        chk("hold_busy", busy[d], 0);
        $display("[TB] dut%0d mode=%0d first_round=%0d edges=%0d", d, m, r0, n);
    endtask

    typedef struct {
        int          d;
        logic        m;
        logic [63:0] w2;
        logic [7:0]  xb;
        int          lat;
    } vec_t;

    vec_t vt [6];

    initial begin
        type_state s, e, a;
        int lat, dcnt, first_e, second_e;

        vt[0] = '{d: 0, m: 1'b1, w2: 64'h0,  xb: 8'h00, lat: 12};
        vt[1] = '{d: 0, m: 1'b0, w2: 64'h0,  xb: 8'h11, lat: 6};
        vt[2] = '{d: 1, m: 1'b0, w2: 64'h0,  xb: 8'h00, lat: 8};
        vt[3] = '{d: 1, m: 1'b1, w2: 64'h0,  xb: 8'h00, lat: 12};
        vt[4] = '{d: 2, m: 1'b1, w2: 64'hFF, xb: 8'hFF, lat: 4};
        vt[5] = '{d: 2, m: 1'b0, w2: 64'hFF, xb: 8'hEE, lat: 2};

        for (int d = 0; d < NDUT; d++) begin
            rstn[d] = 1'b0; start[d] = 1'b0; mode[d] = 1'b0; clr[d] = 1'b0; st_i[d] = '0;
        end
        #12;
        for (int d = 0; d < NDUT; d++) begin
            chk("reset_state", st_o[d], 0);
            chk("reset_round", rnd[d], 0);
            chk("reset_busy", busy[d], 0);
            chk("reset_done", done[d], 0);
        end
        step();
        for (int d = 0; d < NDUT; d++) rstn[d] = 1'b1;
        step();

        // Directed vectors: latency and final byte.
        for (int v = 0; v < 6; v++) begin
            s = '0;
            s[2] = vt[v].w2;
            st_i[vt[v].d] = s; mode[vt[v].d] = vt[v].m; start[vt[v].d] = 1'b1;
            step();
            start[vt[v].d] = 1'b0;
            lat = 0;
            while (!done[vt[v].d] && lat < 40) begin
                step();
                lat++;
            end
            e = s;
            e[2][7:0] = vt[v].xb;
            chk("vec_latency", lat, vt[v].lat);
            chk("vec_state", st_o[vt[v].d], e);
            $display("[TB] vec %0d dut%0d mode=%0d latency=%0d byte=%h", v, vt[v].d, vt[v].m, lat, st_o[vt[v].d][2][7:0]);
            step();
        end

        // UNROLL=3 round sequence, including pb 6,9,12.
        s = '0; s[2] = 64'hFF;
        run_op(2, s, 1'b1);
        run_op(2, s, 1'b0);

        // Asynchronous reset mid-run.
        s = rand_state();
        st_i[0] = s; mode[0] = 1'b1; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rstn[0] = 1'b0;
        #1;
        chk("midreset_state", st_o[0], 0);
        chk("midreset_busy", busy[0], 0);
        chk("midreset_round", rnd[0], 0);
        chk("midreset_done", done[0], 0);
        step();
        rstn[0] = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done[0]) dcnt++;
        end
        chk("midreset_no_done", dcnt, 0);
        chk("midreset_idle", busy[0], 0);

        // start held high: the DONE cycle is the accept edge for the next run.
        s = rand_state();
        st_i[0] = s; mode[0] = 1'b1; start[0] = 1'b1;
        step();
        dcnt = 0; first_e = -1; second_e = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (done[0]) begin
                dcnt++;
                if (first_e < 0) first_e = k;
                else if (second_e < 0) second_e = k;
                chk("held_state", st_o[0], apply_rounds(s, 0, 12));
            end
        end
        start[0] = 1'b0;
        chk("held_done_count", dcnt, 2);
        chk("held_first_done", first_e, 12);
        chk("held_second_done", second_e, 25);
        lat = 0;
        while (!done[0] && lat < 40) begin
            step();
            lat++;
        end
        chk("held_drain", done[0], 1);
        step();

        // start pulsed mid-run with a different state: ignored.
        s = rand_state();
        a = rand_state();
        st_i[0] = s; mode[0] = 1'b1; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        st_i[0] = a; mode[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        lat = 5;
        while (!done[0] && lat < 40) begin
            step();
            lat++;
        end
        chk("pulse_latency", lat, 12);
        chk("pulse_state", st_o[0], apply_rounds(s, 0, 12));
        step();

        // clear at RUN cycle 3, then a full normal run.
        st_i[0] = rand_state(); mode[0] = 1'b1; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        clr[0] = 1'b1; start[0] = 1'b1;
        step();
        clr[0] = 1'b0; start[0] = 1'b0;
        chk("clear_busy", busy[0], 0);
        chk("clear_round", rnd[0], 0);
        chk("clear_state", st_o[0], 0);
        chk("clear_done", done[0], 0);
        dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (done[0] || busy[0]) dcnt++;
        end
        chk("clear_stays_idle", dcnt, 0);
        run_op(0, rand_state(), 1'b1);

        // Randomized operations on all configurations.
        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(NDUT - 1, 0)), rand_state(), 1'($urandom & 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
